// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: initiator side of the word-addressed data-memory port.
// Handles one byte/half/word load or store at a time; sub-word stores are
// done as read-modify-write against the registered-read memory.
// Optional feature macro: DMAU_ALIGN_CHECK_EN. When defined, misaligned, size=11
// and out-of-range requests complete with err=1 and no memory access. When
// undefined, err is tied low, address low bits are masked to the access size,
// size=11 acts as word, and the word index passes through unchecked.
module data_mem_access_unit #(
  parameter int MEM_WORDS = 129
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state, state_next;

  // Latched request
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  // Request decode
  logic [1:0]  size_eff;
  logic [1:0]  lane_eff;
  logic        req_bad;
  logic        word_store;

  // Read-side datapath
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merged;

`ifdef DMAU_ALIGN_CHECK_EN
  logic        err_q;
`else
  logic        idx_range_unused;
  // Out-of-range indices pass through unchecked in this build.
  assign idx_range_unused = ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
`endif

  // Decode the incoming request: effective size, lane and rejection.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    size_eff = size;
    lane_eff = addr[1:0];
    req_bad  = 1'b0;
`ifdef DMAU_ALIGN_CHECK_EN
    req_bad = (size == 2'b11) ||
              (size == SZ_HALF && addr[0]) ||
              (size == SZ_WORD && addr[1:0] != 2'b00) ||
              ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
`else
    if (size == 2'b11) size_eff = SZ_WORD;
    case (size_eff)
      SZ_HALF: lane_eff = {addr[1], 1'b0};
      SZ_WORD: lane_eff = 2'b00;
      default: lane_eff = addr[1:0];
    endcase
`endif
    word_store = we && (size_eff == SZ_WORD);
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (req_bad)         state_next = DONE;
          else if (word_store) state_next = WR;
          else                 state_next = RD;
        end
      end
      RD:      state_next = RWAIT;
      RWAIT:   state_next = we_q ? WR : DONE;
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane extraction, extension and store merge from the registered read word.
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (size_q)
      SZ_BYTE: load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_val = mem_rdata;
    endcase

    merged = mem_rdata;
    if (size_q == SZ_BYTE) begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Latch the request on acceptance; these fields are only read after being loaded.
  // NOTE: the latched request fields carry no reset because nothing reads them before acceptance writes them.
  always_ff @(posedge clk) begin
    if (state == IDLE && req && !rst) begin
      we_q    <= we;
      size_q  <= size_eff;
      uns_q   <= uns;
      lane_q  <= lane_eff;
      wdata_q <= wdata;
    end
  end

  // Visible datapath registers: memory address/data, load result, error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef DMAU_ALIGN_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
`ifdef DMAU_ALIGN_CHECK_EN
            err_q <= req_bad;
`endif
            if (!req_bad) begin
              mem_addr <= {2'b00, addr[31:2]};
              if (word_store) mem_wdata <= wdata;
            end
          end
        end
        RWAIT: begin
          if (we_q) mem_wdata <= merged;
          else      rdata     <= load_val;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign ack    = (state == DONE);
  assign mem_we = (state == WR);
`ifdef DMAU_ALIGN_CHECK_EN
  assign err    = ack & err_q;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Self-checking bench for data_mem_access_unit: directed request sequence with
// a scoreboard of expected completions and a behavioural data memory.
module tb_data_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst, req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, ack, err, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  data_mem_access_unit #(.MEM_WORDS(129)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .busy(busy), .ack(ack), .err(err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous memory (registered read).
  logic        mem_clear;
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [256];
  logic [31:0] model_rdata;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wd;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Compute the expected completion of a request and update the model memory.
  task automatic push_expect(input logic w, input logic [1:0] sz_in, input logic u,
                             input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic [1:0]  sz;
    logic        bad;
    logic [7:0]  idx;
    int          sh;
    logic [31:0] word, mask, v, nw;
    logic        sign;
    sz  = sz_in;
    bad = 1'b0;
`ifdef DMAU_ALIGN_CHECK_EN
    bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
          (a[31:2] >= 30'd129);
`else
    if (sz == 2'b11) sz = 2'b10;
`endif
    idx  = a[9:2];
    sh   = (sz == 2'b00) ? 8 * a[1:0] : (sz == 2'b01) ? 16 * a[1] : 0;
    mask = (sz == 2'b00) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    word = ref_mem[idx];
    e.err   = bad;
    e.nwr   = 0;
    e.waddr = {2'b00, a[31:2]};
    e.wd    = '0;
    if (bad) begin
      e.lat = 1;
    end else if (w) begin
      nw = (word & ~(mask << sh)) | ((d & mask) << sh);
      ref_mem[idx] = nw;
      e.nwr = 1;
      e.wd  = nw;
      e.lat = (sz == 2'b10) ? 2 : 4;
    end else begin
      v = (word >> sh) & mask;
      if (!u && sz != 2'b10) begin
        sign = (sz == 2'b00) ? v[7] : v[15];
        if (sign) v = v | ~mask;
      end
      model_rdata = v;
      e.lat = 3;
    end
    e.rdata = model_rdata;
    sb.push_back(e);
  endtask

  // Issue one request from an IDLE negedge and check its completion.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] d,
                        input bit pulse_rd);
    exp_t        e;
    int          n, lat, nwr;
    bit          got;
    logic [31:0] wa, wd, rd_at_ack, ma_at_ack;
    logic        err_at_ack, busy_at_ack;
    push_expect(w, sz, u, a, d);
    we = w; size = sz; uns = u; addr = a; wdata = d; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    n = 0; lat = 0; nwr = 0; got = 1'b0;
    wa = '0; wd = '0; rd_at_ack = '0; ma_at_ack = '0; err_at_ack = 1'b0; busy_at_ack = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (pulse_rd && n == 2) req = 1'b0;
      if (mem_we) begin
        nwr++;
        wa = mem_addr;
        wd = mem_wdata;
      end
      if (ack) begin
        got = 1'b1;
        lat = n;
        rd_at_ack = rdata;
        ma_at_ack = mem_addr;
        err_at_ack = err;
        busy_at_ack = busy;
      end
      if (pulse_rd && n == 1) begin
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'h0;
      end
    end
    e = sb.pop_front();
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({tag, "_err"}, 32'(err_at_ack), 32'(e.err));
    check({tag, "_rdata"}, rd_at_ack, e.rdata);
    check({tag, "_busy_at_ack"}, 32'(busy_at_ack), 32'd1);
    check({tag, "_mem_we_count"}, 32'(nwr), 32'(e.nwr));
    if (e.nwr != 0) begin
      check({tag, "_wr_addr"}, wa, e.waddr);
      check({tag, "_wr_data"}, wd, e.wd);
    end
    if (!e.err) check({tag, "_mem_addr_at_ack"}, ma_at_ack, e.waddr);
    @(negedge clk);
    check({tag, "_idle_ack"}, 32'(ack), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  // Issue a request and assert reset rst_cycle cycles after acceptance
  // (0 = reset coincides with the accepting edge).
  task automatic do_abort(input string tag, input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d,
                          input int rst_cycle, input int exp_wr);
    int nwr, nack;
    nwr = 0; nack = 0;
    we = w; size = sz; uns = 1'b0; addr = a; wdata = d; req = 1'b1;
    if (rst_cycle == 0) rst = 1'b1;
    @(posedge clk);
    #1 req = 1'b0; rst = 1'b0;
    for (int n = 1; n <= rst_cycle; n++) begin
      @(negedge clk);
      if (mem_we) nwr++;
      if (ack) nack++;
      if (n == rst_cycle) rst = 1'b1;
    end
    if (rst_cycle > 0) begin
      @(posedge clk);
      #1 rst = 1'b0;
    end
    check({tag, "_busy_after_rst"}, 32'(busy), 32'd0);
    model_rdata = '0;
    check({tag, "_rdata_after_rst"}, rdata, model_rdata);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (mem_we) nwr++;
      if (ack) nack++;
    end
    check({tag, "_mem_we_count"}, 32'(nwr), 32'(exp_wr));
    check({tag, "_ack_count"}, 32'(nack), 32'd0);
    if (exp_wr != 0) ref_mem[a[9:2]] = d;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = '0; wdata = '0; mem_clear = 1'b1;
    model_rdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    mem_clear = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Word store / load, sub-word RMW, extension
    do_req("st_w10",   1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    do_req("ld_w10",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b0);
    do_req("st_b12",   1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_0055, 1'b0);
    do_req("ld_b13_s", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0,         1'b0);
    do_req("ld_b13_u", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,         1'b0);
    do_req("ld_h10_s", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0,         1'b0);
    do_req("ld_h12_u", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0,         1'b0);
    do_req("ld_b10_s", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0,         1'b0);
    do_req("st_h16",   1'b1, 2'b01, 1'b0, 32'h16, 32'h1234_ABCD, 1'b0);
    do_req("ld_w14",   1'b0, 2'b10, 1'b0, 32'h14, 32'h0,         1'b0);
    do_req("ld_h14_s", 1'b0, 2'b01, 1'b0, 32'h14, 32'h0,         1'b0);

    // Misaligned / illegal / out-of-range requests (behaviour depends on build)
    do_req("ld_h11",   1'b0, 2'b01, 1'b0, 32'h11,  32'h0,        1'b0);
    do_req("ld_w204",  1'b0, 2'b10, 1'b0, 32'h204, 32'h0,        1'b0);
    do_req("ld_w13",   1'b0, 2'b10, 1'b0, 32'h13,  32'h0,        1'b0);
    do_req("ld_sz3",   1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        1'b0);
    do_req("st_h13",   1'b1, 2'b01, 1'b0, 32'h13,  32'h0000_7777, 1'b0);
    do_req("ld_w10_b", 1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        1'b0);

    // req while busy is ignored
    do_req("ld_busy",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b1);
    do_req("ld_w10_c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b0);

    // Reset during RWAIT of a byte store, during WR, and with req
    do_abort("rst_rwait", 1'b1, 2'b00, 32'h10, 32'h0000_00AA, 2, 0);
    do_req("ld_w10_d", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b0);
    do_abort("rst_wr",    1'b1, 2'b10, 32'h18, 32'hCAFE_F00D, 1, 1);
    do_req("ld_w18",   1'b0, 2'b10, 1'b0, 32'h18, 32'h0,         1'b0);
    do_abort("rst_req",   1'b1, 2'b10, 32'h1C, 32'h1234_5678, 0, 0);
    do_req("ld_w1c",   1'b0, 2'b10, 1'b0, 32'h1C, 32'h0,         1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
